// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: AHB transfer and burst encodings shared by the bus matrix
// input stages and output arbiters.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BUR_SINGLE = 3'd0,
    BUR_INCR   = 3'd1,
    BUR_WRAP4  = 3'd2,
    BUR_INCR4  = 3'd3,
    BUR_WRAP8  = 3'd4,
    BUR_INCR8  = 3'd5,
    BUR_WRAP16 = 3'd6,
    BUR_INCR16 = 3'd7
  } hburst_e;

  // A master starts a transfer when selected, the bus is ready and the
  // transfer type is NONSEQ or SEQ.
  function automatic logic is_new_trans(logic hsel, logic hready, logic [1:0] htrans);
    return hsel & hready & htrans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_input_stage_if.sv
// ahb_mtx_input_stage_if: master-facing AHB slave port of one bus matrix
// input stage. The slave modport is used by the input stage, the master
// modport by whatever drives the port.
interface ahb_mtx_input_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/ahb_mtx_input_stage_addr_hold.sv
// ahb_mtx_addr_hold: address-phase holding registers plus the sel_* mux
// (held phase while pend, live phase otherwise).
// Optional: AHB_MTX_INSTG_SEQ_REMAP_EN re-labels a held SEQ beat as
// NONSEQ/INCR and keeps the rest of that burst presented as INCR.
module ahb_mtx_addr_hold
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              load,
  input  logic              pend,
  input  logic              hsel,
  input  logic              hready,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hlock,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [1:0]        sel_trans,
  output logic              sel_write,
  output logic [2:0]        sel_size,
  output logic [2:0]        sel_burst,
  output logic [3:0]        sel_prot,
  output logic              sel_lock
);

  logic [ADDR_W-1:0] h_addr;
  logic [1:0]        h_trans;
  logic              h_write;
  logic [2:0]        h_size;
  logic [2:0]        h_burst;
  logic [3:0]        h_prot;
  logic              h_lock;

  // Capture the master's address phase when it cannot be forwarded.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      h_addr  <= '0;
      h_trans <= '0;
      h_write <= 1'b0;
      h_size  <= '0;
      h_burst <= '0;
      h_prot  <= '0;
      h_lock  <= 1'b0;
    end else if (load) begin
      h_addr  <= haddr;
      h_trans <= htrans;
      h_write <= hwrite;
      h_size  <= hsize;
      h_burst <= hburst;
      h_prot  <= hprot;
      h_lock  <= hlock;
    end
  end

`ifdef AHB_MTX_INSTG_SEQ_REMAP_EN
  logic remap;

  // Remap flag: set when a broken burst beat (SEQ) is captured, cleared by
  // the master's next live NONSEQ.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remap <= 1'b0;
    end else if (load) begin
      remap <= (htrans == TRN_SEQ);
    end else if (!pend && hsel && hready && (htrans == TRN_NONSEQ)) begin
      remap <= 1'b0;
    end
  end
`endif

  // Present the held phase while pend, otherwise the live phase with the
  // transfer forced to IDLE when the master is not actually issuing.
  always_comb begin
    sel_addr  = haddr;
    sel_trans = (hsel && hready) ? htrans : TRN_IDLE;
    sel_write = hwrite;
    sel_size  = hsize;
    sel_burst = hburst;
    sel_prot  = hprot;
    sel_lock  = hlock;
    if (pend) begin
      sel_addr  = h_addr;
      sel_trans = h_trans;
      sel_write = h_write;
      sel_size  = h_size;
      sel_burst = h_burst;
      sel_prot  = h_prot;
      sel_lock  = h_lock;
    end
`ifdef AHB_MTX_INSTG_SEQ_REMAP_EN
    // A resumed burst restarts as an undefined-length INCR at the new owner.
    if (pend && (h_trans == TRN_SEQ)) begin
      sel_trans = TRN_NONSEQ;
      sel_burst = BUR_INCR;
    end else if (!pend && remap && (htrans == TRN_SEQ)) begin
      sel_burst = BUR_INCR;
    end
`endif
  end

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// ahb_mtx_input_stage: slave-side entry of one master port of the sparse
// AHB bus matrix. Holds an address phase the target output cannot take yet,
// stalls the master until this port is selected, and returns the data-phase
// ready/response. Optional: AHB_MTX_INSTG_SEQ_REMAP_EN (see addr_hold).
module ahb_mtx_input_stage
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PORT_ID = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_mtx_input_stage_if.slave   ahb,
  output logic [ADDR_W-1:0]      sel_addr,
  output logic [1:0]             sel_trans,
  output logic                   sel_write,
  output logic [2:0]             sel_size,
  output logic [2:0]             sel_burst,
  output logic [3:0]             sel_prot,
  output logic                   sel_lock,
  input  logic                   active_dec,
  input  logic                   readyout_dec,
  input  logic                   resp_dec
);

  logic pend;
  logic dph;
  logic new_tr;
  logic accept;
  logic load;
  logic issue;

  assign new_tr = is_new_trans(ahb.HSELS, ahb.HREADYS, ahb.HTRANSS);
  assign accept = active_dec & readyout_dec;
  assign load   = !pend && new_tr && !accept;
  // A transfer reaches the output either by release of the held phase or
  // by live acceptance; both cannot coincide since the master is stalled.
  assign issue  = pend ? accept : (new_tr && accept);

  // Hold / data-phase tracking.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= 1'b0;
      dph  <= 1'b0;
    end else begin
      if (load) begin
        pend <= 1'b1;
      end else if (pend && accept) begin
        pend <= 1'b0;
      end
      if (issue) begin
        dph <= 1'b1;
      end else if (readyout_dec) begin
        dph <= 1'b0;
      end
    end
  end

  // Ready/response back to the master.
  always_comb begin
    ahb.HREADYOUTS = 1'b1;
    ahb.HRESPS     = 1'b0;
    if (pend) begin
      ahb.HREADYOUTS = 1'b0;
    end else if (dph) begin
      ahb.HREADYOUTS = readyout_dec;
    end
    if (dph) begin
      ahb.HRESPS = resp_dec;
    end
  end

  ahb_mtx_addr_hold #(
    .ADDR_W(ADDR_W)
  ) u_addr_hold (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .load     (load),
    .pend     (pend),
    .hsel     (ahb.HSELS),
    .hready   (ahb.HREADYS),
    .haddr    (ahb.HADDRS),
    .htrans   (ahb.HTRANSS),
    .hwrite   (ahb.HWRITES),
    .hsize    (ahb.HSIZES),
    .hburst   (ahb.HBURSTS),
    .hprot    (ahb.HPROTS),
    .hlock    (ahb.HMASTLOCKS),
    .sel_addr (sel_addr),
    .sel_trans(sel_trans),
    .sel_write(sel_write),
    .sel_size (sel_size),
    .sel_burst(sel_burst),
    .sel_prot (sel_prot),
    .sel_lock (sel_lock)
  );

  a_port_id_range: assert property (@(posedge HCLK) PORT_ID < 8);
  a_stall_while_held: assert property (@(posedge HCLK) disable iff (!HRESETn)
    pend |-> !ahb.HREADYOUTS);

endmodule

// File: tb/tb_ahb_mtx_input_stage.sv
// tb_ahb_mtx_input_stage: directed bench for ahb_mtx_input_stage with a
// transaction-level reference model checked on every cycle.
module tb_ahb_mtx_input_stage;
  import ahb_mtx_pkg::*;

`ifdef AHB_MTX_INSTG_SEQ_REMAP_EN
  localparam bit REMAP = 1'b1;
`else
  localparam bit REMAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sel_addr;
  logic [1:0]  sel_trans;
  logic        sel_write;
  logic [2:0]  sel_size;
  logic [2:0]  sel_burst;
  logic [3:0]  sel_prot;
  logic        sel_lock;
  logic        active_dec;
  logic        readyout_dec;
  logic        resp_dec;

  int total = 0;
  int bad   = 0;

  ahb_mtx_input_stage_if #(.ADDR_W(32)) ahb ();

  ahb_mtx_input_stage #(
    .ADDR_W (32),
    .PORT_ID(2)
  ) dut (
    .HCLK        (clk),
    .HRESETn     (rst_n),
    .ahb         (ahb.slave),
    .sel_addr    (sel_addr),
    .sel_trans   (sel_trans),
    .sel_write   (sel_write),
    .sel_size    (sel_size),
    .sel_burst   (sel_burst),
    .sel_prot    (sel_prot),
    .sel_lock    (sel_lock),
    .active_dec  (active_dec),
    .readyout_dec(readyout_dec),
    .resp_dec    (resp_dec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } aph_t;

  aph_t held_q[$];   // address phase waiting for the grant (at most one)
  bit   m_dph;       // a transfer of this master is in its data phase
  bit   m_remap;     // rest of a broken burst is shown as INCR

  function automatic aph_t live_phase();
    aph_t p;
    p.addr  = ahb.HADDRS;
    p.trans = ahb.HTRANSS;
    p.write = ahb.HWRITES;
    p.size  = ahb.HSIZES;
    p.burst = ahb.HBURSTS;
    p.prot  = ahb.HPROTS;
    p.lock  = ahb.HMASTLOCKS;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q.delete();
      m_dph   = 1'b0;
      m_remap = 1'b0;
    end else begin
      bit issuing;
      bit granted;
      bit starting;
      issuing  = ahb.HSELS && ahb.HREADYS;
      starting = issuing && (ahb.HTRANSS == TRN_NONSEQ || ahb.HTRANSS == TRN_SEQ);
      granted  = active_dec && readyout_dec;
      if (held_q.size() != 0) begin
        if (granted) begin
          void'(held_q.pop_front());
          m_dph = 1'b1;
        end else if (readyout_dec) begin
          m_dph = 1'b0;
        end
      end else begin
        if (starting && !granted) begin
          held_q.push_back(live_phase());
          m_remap = (ahb.HTRANSS == TRN_SEQ);
        end else if (issuing && ahb.HTRANSS == TRN_NONSEQ) begin
          m_remap = 1'b0;
        end
        if (starting && granted) m_dph = 1'b1;
        else if (readyout_dec)   m_dph = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      aph_t e;
      bit   e_rdy;
      bit   e_resp;
      if (held_q.size() != 0) begin
        e = held_q[0];
        if (REMAP && e.trans == TRN_SEQ) begin
          e.trans = TRN_NONSEQ;
          e.burst = BUR_INCR;
        end
        e_rdy = 1'b0;
      end else begin
        e = live_phase();
        if (REMAP && m_remap && e.trans == TRN_SEQ) e.burst = BUR_INCR;
        if (!(ahb.HSELS && ahb.HREADYS)) e.trans = TRN_IDLE;
        e_rdy = m_dph ? readyout_dec : 1'b1;
      end
      e_resp = m_dph ? resp_dec : 1'b0;
      check("cmp_hreadyout", ahb.HREADYOUTS, e_rdy);
      check("cmp_hresp", ahb.HRESPS, e_resp);
      check("cmp_addr", sel_addr, e.addr);
      check("cmp_trans", sel_trans, e.trans);
      check("cmp_write", sel_write, e.write);
      check("cmp_size", sel_size, e.size);
      check("cmp_burst", sel_burst, e.burst);
      check("cmp_prot", sel_prot, e.prot);
      check("cmp_lock", sel_lock, e.lock);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic sel, input logic hrdy, input logic [1:0] tr,
                     input logic [31:0] a, input logic [2:0] bur, input logic wr,
                     input logic act, input logic rdo, input logic rsp);
    ahb.HSELS      = sel;
    ahb.HREADYS    = hrdy;
    ahb.HTRANSS    = tr;
    ahb.HADDRS     = a;
    ahb.HBURSTS    = bur;
    ahb.HWRITES    = wr;
    ahb.HSIZES     = a[30:28];
    ahb.HPROTS     = a[31:28];
    ahb.HMASTLOCKS = a[28];
    active_dec     = act;
    readyout_dec   = rdo;
    resp_dec       = rsp;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    check("rst_hreadyout", ahb.HREADYOUTS, 1'b1);
    check("rst_hresp", ahb.HRESPS, 1'b0);
    check("rst_trans", sel_trans, TRN_IDLE);
    next();
    next();
    rst_n = 1'b1;

    // granted pass-through
    drv(1'b1, 1'b1, TRN_NONSEQ, 32'h2000_0000, BUR_SINGLE, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("pt_addr", sel_addr, 32'h2000_0000);
    check("pt_trans", sel_trans, TRN_NONSEQ);
    check("pt_ready", ahb.HREADYOUTS, 1'b1);
    next();
    drv(1'b1, 1'b0, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pt_dph_wait", ahb.HREADYOUTS, 1'b0);
    next();
    drv(1'b1, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("pt_dph_done", ahb.HREADYOUTS, 1'b1);

    // held transfer, granted three cycles later
    next();
    drv(1'b1, 1'b1, TRN_NONSEQ, 32'h4000_0010, BUR_SINGLE, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("hold_first_ready", ahb.HREADYOUTS, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      next();
      drv(1'b1, 1'b0, TRN_NONSEQ, 32'h0, BUR_SINGLE, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("hold_ready", ahb.HREADYOUTS, 1'b0);
      check("hold_addr", sel_addr, 32'h4000_0010);
      check("hold_write", sel_write, 1'b1);
    end
    next();
    drv(1'b1, 1'b0, TRN_NONSEQ, 32'h0, BUR_SINGLE, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("rel_ready", ahb.HREADYOUTS, 1'b0);
    check("rel_addr", sel_addr, 32'h4000_0010);
    next();
    drv(1'b1, 1'b0, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rel_dph_wait", ahb.HREADYOUTS, 1'b0);
    check("rel_live_trans", sel_trans, TRN_IDLE);
    next();
    drv(1'b1, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("rel_dph_done", ahb.HREADYOUTS, 1'b1);

    // two-cycle ERROR with the pipelined transfer cancelled to IDLE
    next();
    drv(1'b1, 1'b1, TRN_NONSEQ, 32'h3000_0000, BUR_SINGLE, 1'b0, 1'b1, 1'b1, 1'b0);
    next();
    drv(1'b1, 1'b0, TRN_NONSEQ, 32'h3000_0004, BUR_SINGLE, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("err1_resp", ahb.HRESPS, 1'b1);
    check("err1_ready", ahb.HREADYOUTS, 1'b0);
    next();
    drv(1'b1, 1'b1, TRN_IDLE, 32'h3000_0004, BUR_SINGLE, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("err2_resp", ahb.HRESPS, 1'b1);
    check("err2_ready", ahb.HREADYOUTS, 1'b1);
    check("err2_trans", sel_trans, TRN_IDLE);
    next();
    drv(1'b1, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("err_after_resp", ahb.HRESPS, 1'b0);
    check("err_no_capture", ahb.HREADYOUTS, 1'b1);

    // BUSY passes live and never captures
    next();
    drv(1'b1, 1'b1, TRN_BUSY, 32'h3000_0008, BUR_INCR, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("busy_trans", sel_trans, TRN_BUSY);
    next();
    drv(1'b1, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("busy_no_capture", ahb.HREADYOUTS, 1'b1);

    // reset while a phase is held
    next();
    drv(1'b1, 1'b1, TRN_NONSEQ, 32'h5000_0000, BUR_SINGLE, 1'b1, 1'b0, 1'b1, 1'b0);
    next();
    drv(1'b1, 1'b0, TRN_NONSEQ, 32'h5000_0000, BUR_SINGLE, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("rh_held", ahb.HREADYOUTS, 1'b0);
    next();
    rst_n = 1'b0;
    #1;
    check("rh_ready", ahb.HREADYOUTS, 1'b1);
    check("rh_trans", sel_trans, TRN_IDLE);
    check("rh_resp", ahb.HRESPS, 1'b0);
    next();
    drv(1'b1, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rh_after_ready", ahb.HREADYOUTS, 1'b1);

    // INCR4 losing ownership before beat 3
    next();
    drv(1'b1, 1'b1, TRN_NONSEQ, 32'h6000_0000, BUR_INCR4, 1'b0, 1'b1, 1'b1, 1'b0);
    next();
    drv(1'b1, 1'b1, TRN_SEQ, 32'h6000_0004, BUR_INCR4, 1'b0, 1'b1, 1'b1, 1'b0);
    next();
    drv(1'b1, 1'b1, TRN_SEQ, 32'h6000_0008, BUR_INCR4, 1'b0, 1'b0, 1'b1, 1'b0);
    next();
    drv(1'b1, 1'b0, TRN_SEQ, 32'h6000_0008, BUR_INCR4, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("sq_held_addr", sel_addr, 32'h6000_0008);
    check("sq_held_trans", sel_trans, REMAP ? TRN_NONSEQ : TRN_SEQ);
    check("sq_held_burst", sel_burst, REMAP ? BUR_INCR : BUR_INCR4);
    next();
    drv(1'b1, 1'b0, TRN_SEQ, 32'h6000_0008, BUR_INCR4, 1'b0, 1'b1, 1'b1, 1'b0);
    next();
    drv(1'b1, 1'b1, TRN_SEQ, 32'h6000_000C, BUR_INCR4, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("sq_live_trans", sel_trans, TRN_SEQ);
    check("sq_live_burst", sel_burst, REMAP ? BUR_INCR : BUR_INCR4);
    next();
    drv(1'b1, 1'b1, TRN_NONSEQ, 32'h7000_0000, BUR_INCR4, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("sq_new_burst", sel_burst, BUR_INCR4);
    next();
    drv(1'b1, 1'b1, TRN_SEQ, 32'h7000_0004, BUR_INCR4, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("sq_new_seq_burst", sel_burst, BUR_INCR4);
    next();
    drv(1'b0, 1'b1, TRN_IDLE, 32'h0, BUR_SINGLE, 1'b0, 1'b0, 1'b1, 1'b0);
    next();
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
